// File: rtl/mac8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac8_seq_ctrl
// Brief    : 8x8 unsigned multiply-accumulate built from one 4x4 vedic
//            multiplier, reused over four nibble steps.
// Revision : 1.0 - initial release
// ============================================================================

module vedic_2bit_multiplier (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic w_t1, w_t2, w_t3, w_c1;

  assign w_t1 = a[1] & b[0];
  assign w_t2 = a[0] & b[1];
  assign w_t3 = a[1] & b[1];
  assign w_c1 = w_t1 & w_t2;
  assign p[0] = a[0] & b[0];
  assign p[1] = w_t1 ^ w_t2;
  assign p[2] = w_t3 ^ w_c1;
  assign p[3] = w_t3 & w_c1;
endmodule

module vedic_4bit_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;

  vedic_2bit_multiplier u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
  vedic_2bit_multiplier u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
  vedic_2bit_multiplier u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
  vedic_2bit_multiplier u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

  // Cross terms sit at weight 4, high term at weight 16.
  assign p = {4'd0, w_q0} + {2'd0, w_q1, 2'd0} + {2'd0, w_q2, 2'd0} + {w_q3, 4'd0};
endmodule

module mac8_seq_ctrl #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_clr,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [15:0]      prod_out,
  output logic             ovf,
  output logic             busy
);
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_mul  = 2'd1;
  localparam logic [1:0] c_acc  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]       r_state, w_next;
  logic [1:0]       r_step;
  logic [7:0]       r_a, r_b;
  logic             r_clr;
  logic [15:0]      r_prod;
  logic [3:0]       w_ma, w_mb;
  logic [7:0]       w_mp;
  logic [3:0]       w_shift;
  logic [15:0]      w_pp;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum;

  // step[1] picks the A nibble, step[0] the B nibble.
  assign w_ma    = r_step[1] ? r_a[7:4] : r_a[3:0];
  assign w_mb    = r_step[0] ? r_b[7:4] : r_b[3:0];
  assign w_shift = {1'b0, r_step[1] & r_step[0], r_step[1] ^ r_step[0], 1'b0} << 1;
  assign w_pp    = {8'd0, w_mp} << w_shift;

  vedic_4bit_multiplier u_mul (.a(w_ma), .b(w_mb), .p(w_mp));

  assign w_prod_ext = ACC_W'(r_prod);
  assign w_sum      = {1'b0, acc_out} + {1'b0, w_prod_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (in_valid) w_next = c_mul;
      c_mul:   if (r_step == 2'd3) w_next = c_acc;
      c_acc:   w_next = c_done;
      default: if (out_ready) w_next = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    busy      = (r_state != c_idle);
    out_valid = (r_state == c_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= 2'd0;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_clr    <= 1'b0;
      r_prod   <= 16'd0;
      acc_out  <= '0;
      prod_out <= 16'd0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          // Clear lands in the same edge as an accept, so the add starts from 0.
          if (acc_clr) begin
            acc_out <= '0;
            ovf     <= 1'b0;
          end
          if (in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_clr  <= in_clr;
            r_prod <= 16'd0;
            r_step <= 2'd0;
          end
        end
        c_mul: begin
          r_prod <= r_prod + w_pp;
          r_step <= r_step + 2'd1;
        end
        c_acc: begin
          if (r_clr) begin
            acc_out <= w_prod_ext;
          end else begin
            acc_out <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) ovf <= 1'b1;
          end
          prod_out <= r_prod;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mac8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac8_seq_ctrl
// Brief    : Directed self-checking bench for mac8_seq_ctrl (ACC_W = 20).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mac8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        in_clr = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] acc_out;
  logic [15:0] prod_out;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad = 0;

  mac8_seq_ctrl #(.ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_clr(in_clr), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .prod_out(prod_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, check latency and leave the DUT sitting in DONE.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                          input logic clr_acc, input logic clr_in_mul);
    @(negedge clk);
    in_a = a; in_b = b; in_clr = clr; acc_clr = clr_acc; in_valid = 1'b1;
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = clr_in_mul;
    in_a = 8'hEE; in_b = 8'hEE;
    repeat (3) @(posedge clk);
    #1 acc_clr = 1'b0;
    @(posedge clk); #1;
    check("lat_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
  endtask

  task automatic release_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_acc", acc_out, 20'h0);
    check("rst_prod", prod_out, 16'h0);
    check("rst_flags", {ovf, out_valid, in_ready, busy}, 4'b0010);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    start_op(8'h0C, 8'h0A, 1'b1, 1'b0, 1'b0);
    check("basic_prod", prod_out, 16'h0078);
    check("basic_acc", acc_out, 20'h00078);
    check("basic_ovf", ovf, 1'b0);
    release_op();

    // Abort an operation mid-MUL with no clock edge involved.
    @(negedge clk);
    in_a = 8'h3C; in_b = 8'hA5; in_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_flags", {ovf, out_valid, in_ready, busy}, 4'b0010);
    check("abort_acc", acc_out, 20'h0);
    check("abort_prod", prod_out, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("abort_no_result", {out_valid, busy, in_ready}, 3'b001);

    start_op(8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("nib_prod", prod_out, 16'h26AC);
    check("nib_acc", acc_out, 20'h026AC);
    release_op();
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check("max_prod", prod_out, 16'hFE01);
    release_op();

    @(negedge clk) acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    check("clr_acc", acc_out, 20'h0);
    for (int i = 0; i < 16; i++) begin
      start_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
      release_op();
    end
    check("acc16_val", acc_out, 20'hFE010);
    check("acc16_ovf", ovf, 1'b0);
    start_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("acc17_val", acc_out, 20'h0DE11);
    check("acc17_ovf", ovf, 1'b1);
    release_op();
    start_op(8'h02, 8'h03, 1'b1, 1'b0, 1'b0);
    check("load_val", acc_out, 20'h00006);
    check("load_ovf_sticky", ovf, 1'b1);
    release_op();

    // Backpressure: DONE holds while a new pair is offered.
    start_op(8'h11, 8'h11, 1'b0, 1'b0, 1'b0);
    in_a = 8'h55; in_b = 8'h55; in_valid = 1'b1; acc_clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, busy}, 3'b101);
      check("bp_acc", acc_out, 20'h00127);
      check("bp_prod", prod_out, 16'h0121);
    end
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0;
    release_op();
    @(posedge clk); #1;
    check("bp_idle_stays", busy, 1'b0);

    start_op(8'h10, 8'h10, 1'b0, 1'b1, 1'b0);
    check("sim_clr_acc", acc_out, 20'h00100);
    check("sim_clr_ovf", ovf, 1'b0);
    release_op();

    start_op(8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
    check("mul_clr_ignored", acc_out, 20'h00104);
    release_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
